// File: rtl/snake_pkg.sv
// Shared encodings, key codes and position helpers for the snake motion block.
package snake_pkg;

    localparam int POS_W      = 13;
    localparam int DEF_GRID_W = 64;
    localparam int DEF_GRID_H = 48;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DEAD  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_SPACE = 8'h29;
    localparam logic [7:0] KEY_ENTER = 8'h5A;

    function automatic logic [6:0] pos_x(input logic [POS_W-1:0] p);
        return p[6:0];
    endfunction

    function automatic logic [5:0] pos_y(input logic [POS_W-1:0] p);
        return p[12:7];
    endfunction

    function automatic logic [POS_W-1:0] pos_pack(input logic [6:0] x,
                                                  input logic [5:0] y);
        return {y, x};
    endfunction

    // Encodings pair up so the reverse direction is the LSB flipped.
    function automatic dir_e dir_opp(input dir_e d);
        return dir_e'(d ^ 2'b01);
    endfunction

endpackage

// File: rtl/snake_next_head.sv
// Next head cell for a given direction, with modulo wrap of the fields
// and a wall flag for anything outside the visible grid.
module snake_next_head
    import snake_pkg::*;
#(
    parameter int GRID_W = DEF_GRID_W,
    parameter int GRID_H = DEF_GRID_H
) (
    input  logic [POS_W-1:0] head_i,
    input  dir_e             dir_i,
    output logic [POS_W-1:0] next_o,
    output logic             wall_o
);

    localparam logic [7:0] GW = 8'(GRID_W);
    localparam logic [6:0] GH = 7'(GRID_H);

    logic [6:0] x;
    logic [6:0] nx;
    logic [5:0] y;
    logic [5:0] ny;

    assign x = pos_x(head_i);
    assign y = pos_y(head_i);

    always_comb begin
        nx = x;
        ny = y;
        unique case (dir_i)
            DIR_UP:    ny = y - 6'd1;
            DIR_DOWN:  ny = y + 6'd1;
            DIR_LEFT:  nx = x - 7'd1;
            DIR_RIGHT: nx = x + 7'd1;
        endcase
    end

    // Wrapped values (127, 63) always land outside the grid.
    assign wall_o = ({1'b0, nx} >= GW) || ({1'b0, ny} >= GH);
    assign next_o = pos_pack(nx, ny);

endmodule

// File: rtl/snake_motion.sv
// Snake game motion core: key handling, game state, body shift and
// wall/self collision detection, one move per step_tick.
module snake_motion
    import snake_pkg::*;
#(
    parameter int SEG_N  = 4,
    parameter int GRID_W = DEF_GRID_W,
    parameter int GRID_H = DEF_GRID_H,
    parameter int INIT_X = 32,
    parameter int INIT_Y = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 key_valid,
    input  logic [7:0]           key_code,
    input  logic                 step_tick,
    output logic [13*SEG_N-1:0]  seg_pos,
    output logic [1:0]           dir,
    output logic [1:0]           state,
    output logic                 died
);

    localparam int SW = POS_W * SEG_N;

    state_e          state_q, state_d, st_mv;
    dir_e            dir_q, dir_d;
    dir_e            pend_q, pend_d;
    logic [SW-1:0]   seg_q, seg_d;
    logic            died_q, died_d;

    logic [SW-1:0]    init_w;
    logic [POS_W-1:0] nh;
    logic             wall;
    logic             self_hit;

    for (genvar k = 0; k < SEG_N; k++) begin : g_init
        assign init_w[POS_W*k +: POS_W] =
            pos_pack(7'(INIT_X - k), 6'(INIT_Y));
    end

    snake_next_head #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H)
    ) u_next (
        .head_i (seg_q[POS_W-1:0]),
        .dir_i  (pend_q),
        .next_o (nh),
        .wall_o (wall)
    );

    // The tail cell is excluded: it vacates on the same move.
    always_comb begin
        self_hit = 1'b0;
        for (int k = 1; k <= SEG_N - 2; k++) begin
            if (seg_q[POS_W*k +: POS_W] == nh) self_hit = 1'b1;
        end
    end

    logic k_up, k_dn, k_lf, k_rt, k_sp, k_en;
    logic arrow_v;
    dir_e arrow_dir;

    assign k_up = key_valid && (key_code == KEY_UP);
    assign k_dn = key_valid && (key_code == KEY_DOWN);
    assign k_lf = key_valid && (key_code == KEY_LEFT);
    assign k_rt = key_valid && (key_code == KEY_RIGHT);
    assign k_sp = key_valid && (key_code == KEY_SPACE);
    assign k_en = key_valid && (key_code == KEY_ENTER);

    always_comb begin
        arrow_v   = 1'b1;
        arrow_dir = DIR_RIGHT;
        unique case (1'b1)
            k_up:    arrow_dir = DIR_UP;
            k_dn:    arrow_dir = DIR_DOWN;
            k_lf:    arrow_dir = DIR_LEFT;
            k_rt:    arrow_dir = DIR_RIGHT;
            default: arrow_v = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        pend_d  = pend_q;
        seg_d   = seg_q;
        died_d  = 1'b0;
        st_mv   = state_q;

        // Move first on pre-key state, then overlay the key.
        if (state_q == ST_RUN && step_tick) begin
            dir_d = pend_q;
            if (wall || self_hit) begin
                st_mv  = ST_DEAD;
                died_d = 1'b1;
            end else begin
                seg_d = {seg_q[POS_W*(SEG_N-1)-1:0], nh};
            end
        end
        state_d = st_mv;

        unique case (st_mv)
            ST_IDLE: begin
                if (k_en) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (k_sp) begin
                    state_d = ST_PAUSE;
                end else if (arrow_v && arrow_dir != dir_opp(dir_d)) begin
                    pend_d = arrow_dir;
                end
            end
            ST_PAUSE: begin
                if (k_sp) state_d = ST_RUN;
            end
            ST_DEAD: begin
                if (k_en && state_q == ST_DEAD) begin
                    state_d = ST_IDLE;
                    seg_d   = init_w;
                    dir_d   = DIR_RIGHT;
                    pend_d  = DIR_RIGHT;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_RIGHT;
            pend_q  <= DIR_RIGHT;
            seg_q   <= init_w;
            died_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
            seg_q   <= seg_d;
            died_q  <= died_d;
        end
    end

    assign seg_pos = seg_q;
    assign dir     = dir_q;
    assign state   = state_q;
    assign died    = died_q;

endmodule
